// File: rtl/drag_race_judge_if.sv
// Signal bundle between the start-tree side and the drag race judge.
// Names carry the judge's point of view: i_* flow into it, o_* come out.
interface drag_race_judge_if;
    logic        i_arm;
    logic        i_green;
    logic        i_lane_a;
    logic        i_lane_b;
    logic [11:0] o_time_a;
    logic [11:0] o_time_b;
    logic        o_foul_a;
    logic        o_foul_b;
    logic        o_win_a;
    logic        o_win_b;
    logic        o_done;

    modport slave (
        input  i_arm, i_green, i_lane_a, i_lane_b,
        output o_time_a, o_time_b, o_foul_a, o_foul_b, o_win_a, o_win_b, o_done
    );

    modport master (
        output i_arm, i_green, i_lane_a, i_lane_b,
        input  o_time_a, o_time_b, o_foul_a, o_foul_b, o_win_a, o_win_b, o_done
    );
endinterface

// File: rtl/drag_race_judge.sv
// Drag race judge: red-light foul detection, reaction timing in ticks and
// winner decision for two lanes. One lane slice per lane holds that lane's
// result; the top holds the race FSM, the shared tick timer and the winner.

// Per-lane result slice: foul flag, captured time, stop/launch status.
module drag_race_lane #(
    parameter int TW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_foul_en,
    input  logic          i_cap_en,
    input  logic          i_tmo,
    input  logic [TW-1:0] i_tick,
    input  logic          i_lane,
    output logic [TW-1:0] o_time,
    output logic [TW-1:0] o_time_nxt,
    output logic          o_foul,
    output logic          o_launch_nxt,
    output logic          o_fin
);
    logic          r_foul;
    logic          r_stop;
    logic          r_launch;
    logic [TW-1:0] r_time;
    logic          w_live;
    logic          w_cap;
    logic          w_to;

    // A lane is live in RUN until it launches, times out or was fouled.
    assign w_live = i_cap_en && !r_foul && !r_stop;
    assign w_cap  = w_live && i_lane;
    assign w_to   = w_live && !i_lane && i_tmo;
    // Finished includes this cycle's capture/timeout so RUN closes on this edge.
    assign o_fin  = r_foul || r_stop || w_cap || w_to;
    assign o_time = r_time;
    assign o_foul = r_foul;

    // Next-cycle result, also used by the winner compare at the closing edge.
    always_comb begin
        o_time_nxt   = r_time;
        o_launch_nxt = r_launch;
        if (w_cap) begin
            o_time_nxt   = i_tick;
            o_launch_nxt = 1'b1;
        end else if (w_to) begin
            o_time_nxt = '1;
        end
    end

    // Lane result registers; cleared on reset, on arming and on abort.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_foul   <= 1'b0;
            r_stop   <= 1'b0;
            r_launch <= 1'b0;
            r_time   <= '0;
        end else begin
            r_time   <= o_time_nxt;
            r_launch <= o_launch_nxt;
            if (w_cap || w_to) r_stop <= 1'b1;
            if (i_foul_en && i_lane) r_foul <= 1'b1;
        end
    end
endmodule

module drag_race_judge #(
    parameter int TICK_DIV = 50000
) (
    input logic              i_clk,
    input logic              i_rst,
    drag_race_judge_if.slave bus
);
    localparam int NUM_LANES = 2;
    localparam int TW        = 12;
    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TMAX = '1;
    localparam logic [TW-1:0] TPRE = TMAX - TW'(1);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_STAGED, S_RUN, S_DONE} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PW-1:0]                 r_presc;
    logic [TW-1:0]                 r_tick;
    logic                          r_done;
    logic [NUM_LANES-1:0]          r_win;
    logic [NUM_LANES-1:0]          w_win_nxt;
    logic [NUM_LANES-1:0]          w_lane;
    logic [NUM_LANES-1:0]          w_foul;
    logic [NUM_LANES-1:0]          w_launch_nxt;
    logic [NUM_LANES-1:0]          w_fin;
    logic [NUM_LANES-1:0][TW-1:0]  w_time;
    logic [NUM_LANES-1:0][TW-1:0]  w_time_nxt;
    logic                          w_clr;
    logic                          w_foul_en;
    logic                          w_cap_en;
    logic                          w_tmr_clr;
    logic                          w_to_done;
    logic                          w_done_clr;
    logic                          w_tmo;

    assign w_lane = {bus.i_lane_b, bus.i_lane_a};

    // Edge at which the tick counter steps onto its saturation value.
    assign w_tmo = (r_tick == TPRE) && (r_presc == PLAST);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        drag_race_lane #(.TW(TW)) u_lane (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_clr        (w_clr),
            .i_foul_en    (w_foul_en),
            .i_cap_en     (w_cap_en),
            .i_tmo        (w_tmo),
            .i_tick       (r_tick),
            .i_lane       (w_lane[g]),
            .o_time       (w_time[g]),
            .o_time_nxt   (w_time_nxt[g]),
            .o_foul       (w_foul[g]),
            .o_launch_nxt (w_launch_nxt[g]),
            .o_fin        (w_fin[g])
        );
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and per-state control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_foul_en   = 1'b0;
        w_cap_en    = 1'b0;
        w_tmr_clr   = 1'b0;
        w_to_done   = 1'b0;
        w_done_clr  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_arm) begin
                    w_state_nxt = S_STAGED;
                    w_clr       = 1'b1;
                end
            end
            S_STAGED: begin
                if (!bus.i_arm) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else if (&w_foul) begin
                    w_state_nxt = S_DONE;
                    w_to_done   = 1'b1;
                end else if (bus.i_green) begin
                    // Green wins over a lane rising in the same cycle.
                    w_state_nxt = S_RUN;
                    w_tmr_clr   = 1'b1;
                end else begin
                    w_foul_en = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.i_arm) begin
                    w_state_nxt = S_IDLE;
                    w_clr       = 1'b1;
                end else begin
                    w_cap_en = 1'b1;
                    if (&w_fin) begin
                        w_state_nxt = S_DONE;
                        w_to_done   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!bus.i_arm) begin
                    w_state_nxt = S_IDLE;
                    w_done_clr  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Prescaler and saturating tick counter, running only in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_tmr_clr) begin
            r_presc <= '0;
            r_tick  <= '0;
        end else if (r_state == S_RUN) begin
            if (r_presc == PLAST) begin
                r_presc <= '0;
                if (r_tick != TMAX) r_tick <= r_tick + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Winner: unfouled, launched, and no better eligible rival (ties share).
    always_comb begin
        w_win_nxt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_win_nxt[i] = !w_foul[i] && w_launch_nxt[i];
            for (int j = 0; j < NUM_LANES; j++) begin
                if (j != i && !w_foul[j] && w_launch_nxt[j] &&
                    (w_time_nxt[i] > w_time_nxt[j]))
                    w_win_nxt[i] = 1'b0;
            end
        end
    end

    // Done and winner flags; winners latch on the edge that enters DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr) begin
            r_done <= 1'b0;
            r_win  <= '0;
        end else if (w_to_done) begin
            r_done <= 1'b1;
            r_win  <= w_win_nxt;
        end else if (w_done_clr) begin
            r_done <= 1'b0;
        end
    end

    assign bus.o_time_a = w_time[0];
    assign bus.o_time_b = w_time[1];
    assign bus.o_foul_a = w_foul[0];
    assign bus.o_foul_b = w_foul[1];
    assign bus.o_win_a  = r_win[0];
    assign bus.o_win_b  = r_win[1];
    assign bus.o_done   = r_done;
endmodule
